// File: rtl/apb_cmd_master_pkg.sv
// Shared constants and types for the APB command master.
package apb_cmd_master_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 16;

    // Wait counter width; covers the full 1..255 timeout range.
    localparam int unsigned TMR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Response error encoding: OK for a clean transfer, ERR for pslverr or timeout.
    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags when the timeout threshold is reached.
module apb_wait_timer
    import apb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic             expired_q;

    // Next count: clear wins, otherwise count waits and hold once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_q) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // Counter and registered threshold flag.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == TMR_W'(TIMEOUT - 1));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/apb_cmd_master.sv
// Converts a valid/ready command into one APB transfer and returns a response.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              cmd_ready_q, psel_q, penable_q, rsp_valid_q;
    logic              tmr_clear, tmr_enable, tmr_expired;

    // Wait-state counter: restarts on SETUP entry, counts ACCESS cycles without pready.
    assign tmr_clear  = (state_d == ST_SETUP);
    assign tmr_enable = (state_q == ST_ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk      (pclk),
        .presetn   (presetn),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    // Next-state, command latch and response capture.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready beats the timeout when both land on the same cycle.
                if (pready) begin
                    rdata_d = write_q ? '0 : prdata;
                    err_d   = pslverr ? RSP_ERR : RSP_OK;
                    state_d = ST_RESP;
                end else if (tmr_expired) begin
                    rdata_d = '0;
                    err_d   = RSP_ERR;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latches and registered outputs decoded from the next state.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= RSP_OK;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q   <= (state_d == ST_ACCESS);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign pwrite    = write_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
